// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings, default geometry
// and the saturating counter update rule used by the BTB.
package bp_pkg;

    localparam int BP_ENTRIES = 16;
    localparam int BP_IDX_W   = 4;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST)
                nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT)
                nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter next-state, purely combinational (0 cycles);
// no handshake, the caller decides when the result is written back.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);

    assign o_cnt = cnt_update(i_cnt, i_taken);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup, one-cycle update,
// and no backpressure except keep, which freezes all updates while held.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDX_W   = BP_IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_PC,
    output logic        pred_taken,
    output logic [31:0] pred_PC,
    input  logic        keep,
    input  logic        upd_valid,
    input  logic [31:0] upd_PC,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int TAG_W = 30 - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [1:0]       r_cnt    [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_f_hit;
    logic             w_u_hit;
    logic             w_upd_en;
    logic [1:0]       w_cnt_nxt;
    logic             w_unused;

    assign w_f_idx = fetch_PC[IDX_W+1:2];
    assign w_f_tag = fetch_PC[31:IDX_W+2];
    assign w_u_idx = upd_PC[IDX_W+1:2];
    assign w_u_tag = upd_PC[31:IDX_W+2];
    assign w_unused = ^{fetch_PC[1:0], upd_PC[1:0]};

    // Lookup reads the registered state, so a same-cycle update is seen next cycle.
    assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign pred_taken = w_f_hit && r_cnt[w_f_idx][1];
    assign pred_PC    = pred_taken ? r_target[w_f_idx] : 32'b0;

    assign w_upd_en = upd_valid && !keep;
    assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    bp_sat_counter u_sat_counter (
        .i_cnt   (r_cnt[w_u_idx]),
        .i_taken (upd_taken),
        .o_cnt   (w_cnt_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= CNT_WNT;
            end
        end else if (w_upd_en) begin
            if (w_u_hit) begin
                r_cnt[w_u_idx] <= w_cnt_nxt;
            end else if (upd_taken) begin
                r_valid[w_u_idx] <= 1'b1;
                r_cnt[w_u_idx]   <= CNT_WT;
            end
        end
    end

    // Tag and target are only meaningful under valid, so they carry no reset;
    // writing the tag on a hit rewrites the same value.
    always_ff @(posedge clk) begin
        if (rst && w_upd_en && upd_taken) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= upd_target;
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of BTB entries; SHALL be a power of two, 4..256.
REQ-002 Parameter IDX_W, default 4, equals log2(ENTRIES); index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2].
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 fetch_PC  input  32  PC of the instruction being fetched this cycle.
REQ-006 pred_taken  output  1  prediction that fetch_PC is a taken branch or jump; consumed by fetch and piped as is_branch_predict.
REQ-007 pred_PC  output  32  predicted target; 32'b0 when pred_taken=0.
REQ-008 keep  input  1  pipeline hold; while 1, the same branch result is presented again.
REQ-009 upd_valid  input  1  resolved control-transfer instruction in MEM (is_branch_pype2).
REQ-010 upd_PC  input  32  PC of the resolved instruction (PC_pype2).
REQ-011 upd_taken  input  1  actual outcome (branch_BTB_contral).
REQ-012 upd_target  input  32  actual target (branch_BTB_PC).

Function
REQ-013 Each entry holds valid (1b), tag, target (32b), and a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-014 Lookup is combinational and zero-latency: pred_taken = valid & tag match & counter[1]; pred_PC = stored target when pred_taken, else 0.
REQ-015 An update SHALL be performed on a rising edge only when upd_valid=1 and keep=0; with keep=1 no entry changes, so a held instruction is never counted twice.
REQ-016 Hit (valid, tag match) with upd_taken=1: counter increments, saturating at 11; target overwritten with upd_target.
REQ-017 Hit with upd_taken=0: counter decrements, saturating at 00; target unchanged; valid stays 1.
REQ-018 Miss with upd_taken=1: entry allocated or replaced: valid=1, tag from upd_PC, target=upd_target, counter=10.
REQ-019 Miss with upd_taken=0: no state change (never-taken branches never allocate).
REQ-020 Lookup and update to the same index in the same cycle: the lookup returns pre-update contents; the new contents become visible on the next cycle.
REQ-021 upd_target with bits [1:0] != 00 (misaligned, exception path) SHALL still be stored unmodified; the predictor does not filter it.
REQ-022 Index and tag use only upd_PC and fetch_PC bits; bits [1:0] are ignored.
REQ-023 No other entry changes on any update; all other storage holds its value.

Reset
REQ-024 rst=0 clears every valid bit and sets every counter to 01 asynchronously; tags and targets need not be reset.
REQ-025 While in reset, and in the first cycle after release, pred_taken=0 and pred_PC=0 for every fetch_PC.
REQ-026 Reset asserted mid-update discards the update; no entry is valid after reset.

Structure
REQ-027 Shared package bp_pkg SHALL hold counter encodings (CNT_SNT, CNT_WNT, CNT_WT, CNT_ST), the counter-update function, and default ENTRIES/IDX_W.
REQ-028 Storage SHALL be flops (no RAM macro) so reset clear and same-cycle lookup are single-cycle.
REQ-029 One sub-module, bp_sat_counter (2-bit increment/decrement with saturation), is natural; everything else stays in branch_predictor.

Verification
REQ-030 After reset, lookup 0x0000_0040 -> pred_taken=0, pred_PC=0; update PC 0x40, taken, target 0x100 -> next cycle lookup 0x40 gives pred_taken=1, pred_PC=0x100.
REQ-031 Entry at counter 10; two not-taken updates -> counter 00, pred_taken=0; one taken update -> counter 01, still 0; second taken update -> 10, pred_taken=1.
REQ-032 Aliasing (ENTRIES=16): 0x40 allocated taken to 0x100; update 0x80 (same index 0, different tag) taken to 0x200 -> lookup 0x40 pred_taken=0; lookup 0x80 pred_PC=0x200.
REQ-033 keep=1 for 3 cycles with upd_valid=1, taken, PC 0x40 at counter 10 -> counter stays 10; keep drops -> exactly one increment to 11.
REQ-034 fetch_PC=0x40 and update 0x40 taken to 0x300 in the same cycle -> that cycle returns the old target; the next cycle returns 0x300.
REQ-035 Miss with not-taken update for PC 0x44 -> no allocation; lookup 0x44 pred_taken=0; rst pulse mid-run -> all lookups return 0.
